tt_um_serial_adder: RTL and testbench

Bit-serial 4-bit adder stage that extends the combinational half-adder tile into a clocked datapath. Two 4-bit operands are captured in parallel from the dedicated inputs, then summed LSB-first through a single registered full-adder cell, one bit per clock. The 5-bit result and status flags go to the dedicated outputs. The block is the next tile in the adder series and shares its pin map style.

---
 rtl/tt_um_serial_adder_if.sv | 28 ++
 rtl/tt_um_serial_adder.sv | 98 +++++++++
 tb/tb_tt_um_serial_adder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_um_serial_adder_if.sv
// Pin bundle for the serial adder tile.
// Mirrors the shared dedicated/bidirectional IO map of the adder series.
interface tt_um_serial_adder_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/tt_um_serial_adder.sv
// Bit-serial 4-bit adder: capture, four LSB-first steps, one DONE cycle.
// Optional subtract mode behind SERIAL_ADDER_SUB_EN.
module tt_um_serial_adder (
    input  logic                  clk,
    input  logic                  rst_n,
    tt_um_serial_adder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] shift_a;
    logic [3:0] shift_b;
    logic [3:0] sum_sr;
    logic [4:0] result;
    logic [1:0] cnt;
    logic       carry;
    logic       zero;

    logic       start;
    logic [3:0] b_cap;
    logic       c_cap;
    logic       s;
    logic       carry_next;
    logic [3:0] sum_next;
    logic       unused;

    assign start = bus.uio_in[0];

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract is A + ~B + 1, folded into the capture.
    assign b_cap = bus.uio_in[1] ? ~bus.ui_in[7:4] : bus.ui_in[7:4];
    assign c_cap = bus.uio_in[1];
`else
    assign b_cap = bus.ui_in[7:4];
    assign c_cap = 1'b0;
`endif

    assign unused = ^bus.uio_in[7:1];

    assign s          = shift_a[0] ^ shift_b[0] ^ carry;
    assign carry_next = (shift_a[0] & shift_b[0])
                      | (shift_a[0] & carry)
                      | (shift_b[0] & carry);
    assign sum_next   = {s, sum_sr[3:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift_a <= 4'd0;
            shift_b <= 4'd0;
            sum_sr  <= 4'd0;
            result  <= 5'd0;
            cnt     <= 2'd0;
            carry   <= 1'b0;
            zero    <= 1'b0;
        end else if (bus.ena) begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shift_a <= bus.ui_in[3:0];
                        shift_b <= b_cap;
                        carry   <= c_cap;
                        cnt     <= 2'd0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    carry   <= carry_next;
                    shift_a <= {1'b0, shift_a[3:1]};
                    shift_b <= {1'b0, shift_b[3:1]};
                    sum_sr  <= sum_next;
                    cnt     <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        result <= {carry_next, sum_next};
                        zero   <= (sum_next == 4'b0000);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.uo_out  = {zero, state == DONE, state == SHIFT, result};
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_serial_adder.sv
// Randomized self-checking bench for tt_um_serial_adder.
// Expected sums come from plain integer arithmetic.
module tb_tt_um_serial_adder;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    tt_um_serial_adder_if bus ();

    tt_um_serial_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] model(
        input int a, input int b, input bit sub);
        int r;
        if (sub) r = a + ((~b) & 15) + 1;
        else     r = a + b;
        return r[4:0];
    endfunction

    // Presents operands with start high for one edge; returns after capture.
    task automatic kick(input logic [3:0] a, input logic [3:0] b,
                        input bit sub);
        @(negedge clk);
        bus.ui_in  = {b, a};
        bus.uio_in = {6'b0, sub, 1'b1};
        @(negedge clk);
        bus.uio_in[0] = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.uo_out[6]) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.uo_out !== 8'h00) begin
            fails++;
            $display("FAIL reset_uo got %h want 00", bus.uo_out);
        end
        tests++;
        if (bus.uio_out !== 8'h00 || bus.uio_oe !== 8'h00) begin
            fails++;
            $display("FAIL reset_uio got %h/%h want 00/00",
                     bus.uio_out, bus.uio_oe);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.uo_out !== 8'h00) begin
            fails++;
            $display("FAIL idle_after_reset got %h want 00", bus.uo_out);
        end
    endtask

    task automatic test_basic;
        kick(4'd3, 4'd5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (bus.uo_out[6:5] !== 2'b01) begin
                fails++;
                $display("FAIL basic_busy%0d got %b want 01",
                         i, bus.uo_out[6:5]);
            end
            @(negedge clk);
        end
        tests++;
        if (bus.uo_out !== 8'b0100_1000) begin
            fails++;
            $display("FAIL basic_done got %b want 01001000", bus.uo_out);
        end
        @(negedge clk);
        tests++;
        if (bus.uo_out !== 8'b0000_1000) begin
            fails++;
            $display("FAIL basic_after got %b want 00001000", bus.uo_out);
        end
    endtask

    task automatic test_corners;
        logic [3:0] av [4] = '{4'd15, 4'd0, 4'd8, 4'd9};
        logic [3:0] bv [4] = '{4'd15, 4'd0, 4'd8, 4'd6};
        logic [4:0] exp;
        int n;
        for (int k = 0; k < 4; k++) begin
            kick(av[k], bv[k], 1'b0);
            // zero from the previous op must survive the capture
            if (k == 2) begin
                tests++;
                if (bus.uo_out[7] !== 1'b1) begin
                    fails++;
                    $display("FAIL zero_hold got %b want 1", bus.uo_out[7]);
                end
            end
            wait_done(n);
            exp = model(av[k], bv[k], 1'b0);
            tests++;
            if (n !== 4 || bus.uo_out[4:0] !== exp
                || bus.uo_out[7] !== (exp[3:0] == 4'd0)) begin
                fails++;
                $display("FAIL corner%0d lat %0d res %b z %b want 4 %b %b",
                         k, n, bus.uo_out[4:0], bus.uo_out[7],
                         exp, exp[3:0] == 4'd0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] exp;
        int n;
        for (int k = 0; k < 10; k++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            kick(a, b, 1'b0);
            bus.ui_in = 8'($urandom);
            wait_done(n);
            exp = model(a, b, 1'b0);
            tests++;
            if (n !== 4 || bus.uo_out[4:0] !== exp) begin
                fails++;
                $display("FAIL rand %0d+%0d lat %0d res %0d want 4 %0d",
                         a, b, n, bus.uo_out[4:0], exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int first;
        int second;
        first  = -1;
        second = -1;
        @(negedge clk);
        bus.ui_in  = {4'd2, 4'd1};
        bus.uio_in = 8'h01;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.uo_out[6]) begin
                if (first < 0) begin
                    first = i;
                    tests++;
                    if (bus.uo_out[4:0] !== 5'd3) begin
                        fails++;
                        $display("FAIL b2b_first got %0d want 3",
                                 bus.uo_out[4:0]);
                    end
                    bus.ui_in = {4'd9, 4'd7};
                end else begin
                    second = i;
                    tests++;
                    if (bus.uo_out[4:0] !== 5'd16) begin
                        fails++;
                        $display("FAIL b2b_second got %0d want 16",
                                 bus.uo_out[4:0]);
                    end
                    bus.uio_in = 8'h00;
                    break;
                end
            end
        end
        bus.uio_in = 8'h00;
        tests++;
        if (first < 0 || second - first !== 6) begin
            fails++;
            $display("FAIL b2b_spacing got %0d want 6", second - first);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        kick(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.uo_out !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid got %h want 00", bus.uo_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        kick(4'd4, 4'd4, 1'b0);
        wait_done(n);
        tests++;
        if (n !== 4 || bus.uo_out[4:0] !== 5'd8) begin
            fails++;
            $display("FAIL after_reset lat %0d res %0d want 4 8",
                     n, bus.uo_out[4:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_ena_stall;
        logic [3:0] a;
        logic [3:0] b;
        int n;
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        n = -1;
        kick(a, b, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.uo_out[6]) begin
                n = i;
                break;
            end
            if (i == 1) bus.ena = 1'b0;
            if (i == 4) bus.ena = 1'b1;
        end
        bus.ena = 1'b1;
        tests++;
        if (n !== 7 || bus.uo_out[4:0] !== model(a, b, 1'b0)) begin
            fails++;
            $display("FAIL ena_stall lat %0d res %0d want 7 %0d",
                     n, bus.uo_out[4:0], model(a, b, 1'b0));
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        logic [3:0] av [3] = '{4'd5, 4'd3, 4'd6};
        logic [3:0] bv [3] = '{4'd3, 4'd5, 4'd6};
        logic [4:0] exp;
        int n;
        for (int k = 0; k < 3; k++) begin
            kick(av[k], bv[k], 1'b1);
            wait_done(n);
            exp = model(av[k], bv[k], 1'b1);
            tests++;
            if (n !== 4 || bus.uo_out[4:0] !== exp
                || bus.uo_out[7] !== (exp[3:0] == 4'd0)) begin
                fails++;
                $display("FAIL sub%0d lat %0d res %b z %b want 4 %b",
                         k, n, bus.uo_out[4:0], bus.uo_out[7], exp);
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_ena_stall();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
